vector_lsu: RTL and testbench

Vector load/store unit that issues 256-bit requests on the vector port of the unified instruction/scalar/vector memory. That port is currently tied off in the FIR filter top level. The unit accepts one request at a time from the processor's vector datapath over a valid/ready handshake, sequences one or two aligned line accesses, and returns a single-cycle response pulse. Optionally, it merges two lines to serve unaligned loads.

---
 rtl/vector_lsu.sv | 158 +++++++++++++++
 tb/tb_vector_lsu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lsu.sv
// Vector load/store unit: one request at a time over valid/ready, one or two
// aligned 256-bit line accesses on the vector memory port, one-cycle response.
// Optional feature macro: VLSU_UNALIGNED_EN (merges two lines for unaligned loads).
module vector_lsu #(
  parameter int unsigned N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [N-1:0]   req_addr,
  input  logic [255:0]   req_wdata,
  output logic           rsp_valid,
  output logic [255:0]   rsp_rdata,
  output logic           rsp_error,
  output logic [N-1:0]   data_address_vector,
  output logic [255:0]   write_data_vector,
  output logic           MemWrite_vector,
  input  logic [255:0]   read_data_vector
);

  localparam int unsigned LINE_W     = 256;
  localparam int unsigned OFF_W      = 5;
  localparam int unsigned LINE_BYTES = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2, RESP} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [N-1:0]        addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [N-1:0]        line0_c;

`ifdef VLSU_UNALIGNED_EN
  logic [LINE_W-1:0]   buf0_q, buf0_d;
  logic [LINE_W-1:0]   merged_c;

  // Byte-granular window starting at the offset into {second line, first line}
  assign merged_c = LINE_W'({read_data_vector, buf0_q} >> {off_q, 3'b000});
`endif

  assign line0_c   = {req_addr[N-1:OFF_W], OFF_W'(0)};
  assign req_ready = (state_q == IDLE) && en && !rst;

  assign data_address_vector = addr_q;
  assign write_data_vector   = wdata_q;
  assign MemWrite_vector     = we_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_rdata           = rdata_q;
  assign rsp_error           = err_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    off_d       = off_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef VLSU_UNALIGNED_EN
    buf0_d      = buf0_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          off_d   = req_addr[OFF_W-1:0];
          state_d = ACCESS;
          // Address/strobe are registered so they are live during ACCESS
          if (!req_write || (req_addr[OFF_W-1:0] == OFF_W'(0))) begin
            addr_d = line0_c;
          end
          if (req_write && (req_addr[OFF_W-1:0] == OFF_W'(0))) begin
            we_d    = 1'b1;
            wdata_d = req_wdata;
          end
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        if (write_q) begin
          rdata_d = '0;
          err_d   = (off_q != OFF_W'(0));
        end else if (off_q == OFF_W'(0)) begin
          rdata_d = read_data_vector;
          err_d   = 1'b0;
        end else begin
`ifdef VLSU_UNALIGNED_EN
          buf0_d      = read_data_vector;
          addr_d      = addr_q + N'(LINE_BYTES);
          state_d     = ACCESS2;
          rsp_valid_d = 1'b0;
`else
          rdata_d = '0;
          err_d   = 1'b1;
`endif
        end
      end
`ifdef VLSU_UNALIGNED_EN
      ACCESS2: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rdata_d     = merged_c;
        err_d       = 1'b0;
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      off_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef VLSU_UNALIGNED_EN
      buf0_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef VLSU_UNALIGNED_EN
      buf0_q      <= buf0_d;
`endif
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Bench for vector_lsu: bench-side line memory, spec-level model of responses,
// per-cycle compare process and a few literal checks.
`timescale 1ns/1ps
module tb_vector_lsu;

  localparam int unsigned N = 24;
`ifdef VLSU_UNALIGNED_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, en, req_valid, req_ready, req_write;
  logic [N-1:0]   req_addr;
  logic [255:0]   req_wdata;
  logic           rsp_valid, rsp_error, MemWrite_vector;
  logic [255:0]   rsp_rdata, write_data_vector, read_data_vector;
  logic [N-1:0]   data_address_vector;

  always #5 clk = ~clk;

  vector_lsu #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .data_address_vector(data_address_vector), .write_data_vector(write_data_vector),
    .MemWrite_vector(MemWrite_vector), .read_data_vector(read_data_vector)
  );

  // Physical memory: 32 lines, aliased on address bits [9:5]
  logic [255:0] mem [32];
  logic         mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (MemWrite_vector) begin
      mem[data_address_vector[9:5]] <= write_data_vector;
    end
  end
  assign read_data_vector = mem[data_address_vector[9:5]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rst_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: memory contents by full line address
  logic [255:0] model_mem [int];
  typedef struct { logic err; logic [255:0] rdata; } rsp_t;
  rsp_t         exp_rsp  [int];
  logic [255:0] exp_wr   [int];
  logic [N-1:0] exp_addr [int];
  int busy_lo = 1;
  int busy_hi = 0;

  function automatic logic [255:0] mline(input logic [N-1:0] la);
    if (model_mem.exists(int'(la))) return model_mem[int'(la)];
    return '0;
  endfunction

  function automatic logic [255:0] pat(input logic [7:0] base);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = base + 8'(i);
    return v;
  endfunction

  // Load result: 32 consecutive bytes starting at addr, across the line pair
  function automatic logic [255:0] model_load(input logic [N-1:0] a);
    logic [N-1:0] l0, l1;
    logic [255:0] d0, d1, r;
    logic [7:0]   bytes [64];
    int           o;
    l0 = {a[N-1:5], 5'b0};
    l1 = l0 + N'(32);
    d0 = mline(l0);
    d1 = mline(l1);
    o  = int'(a[4:0]);
    for (int i = 0; i < 32; i++) begin
      bytes[i]      = d0[8*i +: 8];
      bytes[i + 32] = d1[8*i +: 8];
    end
    for (int i = 0; i < 32; i++) r[8*i +: 8] = bytes[o + i];
    return r;
  endfunction

  // Issue a request and record what the spec says must follow it
  task automatic do_req(input logic w, input logic [N-1:0] a, input logic [255:0] wd,
                        input bit kill, output int acc);
    logic r;
    bit   unal_ld;
    int   lat;
    logic [N-1:0] l0;
    rsp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    acc = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #1;
      if (r) begin acc = cyc; break; end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h got=no_accept want=accept", a);
      return;
    end
    l0      = {a[N-1:5], 5'b0};
    unal_ld = !w && (a[4:0] != 5'd0);
    lat     = (unal_ld && UNAL) ? 2 : 1;
    if (!w || a[4:0] == 5'd0) exp_addr[acc] = l0;
    if (unal_ld && UNAL) exp_addr[acc + 1] = l0 + N'(32);
    e.err   = (a[4:0] != 5'd0) && (w || !UNAL);
    e.rdata = (w || e.err) ? 256'd0 : model_load(a);
    if (w && a[4:0] == 5'd0) begin
      exp_wr[acc] = wd;
      model_mem[int'(l0)] = wd;
    end
    if (!kill) exp_rsp[acc + lat] = e;
    busy_lo = acc;
    busy_hi = kill ? acc : acc + lat;
  endtask

  // Per-cycle comparison of every observable output against the model
  logic [255:0] last_rdata = '0;
  logic         last_err   = 1'b0;
  always @(negedge clk) begin
    bit ev, ew;
    if (cyc >= 1) begin
      if (rst_at_edge) begin
        last_rdata = '0;
        last_err   = 1'b0;
        chk("rst_addr",  256'(data_address_vector), 256'd0);
        chk("rst_wdata", write_data_vector, 256'd0);
      end
      ev = exp_rsp.exists(cyc);
      if (ev) begin
        last_rdata = exp_rsp[cyc].rdata;
        last_err   = exp_rsp[cyc].err;
      end
      chk("rsp_valid", 256'(rsp_valid), 256'(ev));
      chk("rsp_rdata", rsp_rdata, last_rdata);
      chk("rsp_error", 256'(rsp_error), 256'(last_err));
      ew = exp_wr.exists(cyc);
      chk("memwrite", 256'(MemWrite_vector), 256'(ew));
      if (ew) chk("wdata", write_data_vector, exp_wr[cyc]);
      if (exp_addr.exists(cyc)) chk("addr", 256'(data_address_vector), 256'(exp_addr[cyc]));
      chk("req_ready", 256'(req_ready),
          256'(en && !rst && !(cyc >= busy_lo && cyc <= busy_hi)));
    end
  end

  task automatic negs(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int acc;
    logic [255:0] m;
    rst = 1'b1; en = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 256'(req_ready), 256'd1);

    // Aligned stores filling the lines used below
    do_req(1'b1, 24'h000040, pat(8'h00), 1'b0, acc);
    negs(2);
    chk("store_rsp_err", 256'(rsp_error), 256'd0);
    do_req(1'b1, 24'h000060, pat(8'h20), 1'b0, acc);
    do_req(1'b1, 24'hFFFFE0, pat(8'hE0), 1'b0, acc);
    do_req(1'b1, 24'h000000, pat(8'hA0), 1'b0, acc);

    // Aligned load: byte i = i
    do_req(1'b0, 24'h000040, '0, 1'b0, acc);
    negs(2);
    chk("lit_load40", rsp_rdata,
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);

    // Unaligned load at 0x45
    do_req(1'b0, 24'h000045, '0, 1'b0, acc);
    negs(UNAL ? 3 : 2);
    if (UNAL) begin
      chk("lit_load45", rsp_rdata,
          256'h24232221201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a0908070605);
    end else begin
      chk("lit_load45_err", 256'(rsp_error), 256'd1);
    end
    m = model_load(24'h000045);
    chk("model_pin45", 256'(m[7:0]), 256'h05);

    // Misaligned store is rejected and leaves memory untouched
    do_req(1'b1, 24'h000041, pat(8'h77), 1'b0, acc);
    negs(2);
    chk("misstore_err", 256'(rsp_error), 256'd1);
    do_req(1'b0, 24'h000040, '0, 1'b0, acc);
    negs(2);
    chk("lit_reload40", rsp_rdata,
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);

    // Top-line wrap
    do_req(1'b0, 24'hFFFFF0, '0, 1'b0, acc);
    negs(UNAL ? 3 : 2);
    if (UNAL) begin
      chk("lit_wrap", rsp_rdata,
          256'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0fffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
    end else begin
      chk("lit_wrap_err", 256'(rsp_error), 256'd1);
    end

    // A few more offsets through the model
    do_req(1'b0, 24'h00005F, '0, 1'b0, acc);
    do_req(1'b0, 24'h000061, '0, 1'b0, acc);
    do_req(1'b0, 24'h000060, '0, 1'b0, acc);

    // en dropped during ACCESS: in-flight response still arrives
    do_req(1'b0, 24'h000043, '0, 1'b0, acc);
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1 en = 1'b1;
    negs(1);

    // Reset held two cycles during a store's ACCESS: write lands, no response
    do_req(1'b1, 24'h000080, pat(8'h50), 1'b1, acc);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    negs(1);
    chk("ready_post_rst", 256'(req_ready), 256'd1);
    do_req(1'b0, 24'h000080, '0, 1'b0, acc);
    negs(2);
    chk("lit_load80", rsp_rdata,
        256'h6f6e6d6c6b6a696867666564636261605f5e5d5c5b5a59585756555453525150);

    repeat (6) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
